// File: rtl/dummy_arbiter_if.sv
// Bus bundle between NReq requesters, the round-robin arbiter and the single
// bitwise-OR accelerator slave port.
//   requester side : req_i/we_i/be_i/addr_i/wdata_i/lock_i in, gnt_o/rvalid_o/rdata_o out
//   accelerator    : acc_req_o/acc_we_o/acc_be_o/acc_addr_o/acc_wdata_o out,
//                    acc_rvalid_i/acc_rdata_i in
//   lock_release_o : one-cycle pulse when a stale lock is dropped by the watchdog
// Suffixes are from the arbiter's point of view; modport slave is the arbiter,
// modport master is whatever surrounds it (requesters + accelerator).
interface dummy_arbiter_if #(
    parameter int NReq = 2
) ();
    logic [NReq-1:0]      req_i;
    logic [NReq-1:0]      we_i;
    logic [4*NReq-1:0]    be_i;
    logic [32*NReq-1:0]   addr_i;
    logic [32*NReq-1:0]   wdata_i;
    logic [NReq-1:0]      lock_i;
    logic [NReq-1:0]      gnt_o;
    logic [NReq-1:0]      rvalid_o;
    logic [32*NReq-1:0]   rdata_o;
    logic                 acc_req_o;
    logic                 acc_we_o;
    logic [3:0]           acc_be_o;
    logic [31:0]          acc_addr_o;
    logic [31:0]          acc_wdata_o;
    logic                 acc_rvalid_i;
    logic [31:0]          acc_rdata_i;
    logic                 lock_release_o;

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, lock_i, acc_rvalid_i, acc_rdata_i,
        output gnt_o, rvalid_o, rdata_o, acc_req_o, acc_we_o, acc_be_o, acc_addr_o,
               acc_wdata_o, lock_release_o
    );

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, lock_i, acc_rvalid_i, acc_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, acc_req_o, acc_we_o, acc_be_o, acc_addr_o,
               acc_wdata_o, lock_release_o
    );
endinterface

// File: rtl/dummy_arbiter.sv
// Round-robin arbiter sharing one accelerator port between NReq requesters.
// A requester can lock the accelerator across several accesses; a watchdog
// drops the lock after LockTimeout idle cycles of the owner. The single
// in-flight access is tracked so the response returns to its issuer.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset
//   bus    - dummy_arbiter_if.slave (requester and accelerator signals)
module dummy_arbiter #(
    parameter int NReq        = 2,
    parameter int LockTimeout = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dummy_arbiter_if.slave bus
);
    localparam int IdxW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int CntW = (LockTimeout > 1) ? $clog2(LockTimeout) : 1;

    typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

    lock_state_e     state_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] owner_q;
    logic [IdxW-1:0] rsp_id_q;
    logic            pend_q;
    logic [CntW-1:0] idle_cnt_q;

    logic            lock_q;
    logic [NReq-1:0] elig;
    logic            win_vld;
    logic [IdxW-1:0] win;
    logic            grant;
    logic            timeout;

    assign lock_q = (state_q == LOCKED);

    // Under lock only the owner may compete; otherwise scan from rr_ptr_q
    // upwards with wrap-around and take the first requester found.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        elig    = lock_q ? (bus.req_i & (NReq'(1) << owner_q)) : bus.req_i;
        win_vld = 1'b0;
        win     = '0;
        for (int k = 0; k < NReq; k++) begin
            idx = (int'(rr_ptr_q) + k) % NReq;
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win     = IdxW'(idx);
            end
        end
    end

    // Gate with the reset level so nothing is issued while reset is held.
    assign grant = win_vld & rst_ni;

    assign bus.gnt_o       = grant ? (NReq'(1) << win) : '0;
    assign bus.acc_req_o   = grant;
    assign bus.acc_we_o    = grant & bus.we_i[win];
    assign bus.acc_be_o    = grant ? bus.be_i[4*int'(win) +: 4] : '0;
    assign bus.acc_addr_o  = grant ? bus.addr_i[32*int'(win) +: 32] : '0;
    assign bus.acc_wdata_o = grant ? bus.wdata_i[32*int'(win) +: 32] : '0;

    // Watchdog fires on the idle cycle where the count has reached its limit.
    assign timeout            = lock_q & ~bus.req_i[owner_q] &
                                (idle_cnt_q == CntW'(LockTimeout - 1));
    assign bus.lock_release_o = timeout;

    // Fixed one-cycle slave latency: the response belongs to last cycle's grant.
    always_comb begin
        bus.rvalid_o = '0;
        bus.rdata_o  = '0;
        if (pend_q && bus.acc_rvalid_i) begin
            bus.rvalid_o[rsp_id_q]              = 1'b1;
            bus.rdata_o[32*int'(rsp_id_q) +: 32] = bus.acc_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= UNLOCKED;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            rsp_id_q   <= '0;
            pend_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            pend_q <= grant;
            if (grant) begin
                rr_ptr_q <= (win == IdxW'(NReq - 1)) ? '0 : win + 1'b1;
                rsp_id_q <= win;
            end
            case (state_q)
                UNLOCKED: begin
                    idle_cnt_q <= '0;
                    if (grant && bus.lock_i[win]) begin
                        state_q <= LOCKED;
                        owner_q <= win;
                    end
                end
                LOCKED: begin
                    // An owner request is always granted while locked, so
                    // the unlock test only needs the owner's lock bit.
                    if (bus.req_i[owner_q]) begin
                        idle_cnt_q <= '0;
                        if (grant && !bus.lock_i[win]) state_q <= UNLOCKED;
                    end else if (timeout) begin
                        state_q    <= UNLOCKED;
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: state_q <= UNLOCKED;
            endcase
        end
    end
endmodule

// File: tb/tb_dummy_arbiter.sv
// Self-checking bench for dummy_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (owner index, last-activity timestamp, last grant).
module tb_dummy_arbiter;
    localparam int N  = 2;
    localparam int LT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dummy_arbiter_if #(.NReq(N)) bus ();

    dummy_arbiter #(.NReq(N), .LockTimeout(LT)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- accelerator model: OR of the two operand registers -----
    logic [31:0] s_a = '0, s_b = '0, s_data = '0;
    logic        s_req = 1'b0;
    bit          spur = 1'b0;   // inject a response nobody asked for

    initial begin
        bus.acc_rvalid_i = 1'b0;
        bus.acc_rdata_i  = '0;
        forever begin
            @(negedge clk);
            s_req = bus.acc_req_o;
            if (bus.acc_req_o && bus.acc_we_o) begin
                if (bus.acc_addr_o[2]) s_b = bus.acc_wdata_o;
                else                   s_a = bus.acc_wdata_o;
            end
            s_data = (bus.acc_req_o && !bus.acc_we_o) ? (s_a | s_b) : 32'h0;
            @(posedge clk);
            #1;
            bus.acc_rvalid_i = s_req | spur;
            bus.acc_rdata_i  = s_req ? s_data : $urandom;
        end
    end

    // ---------------- reference model + per-cycle compare -------------------
    int           m_ptr   = 0;
    int           m_owner = -1;  // -1: nobody holds the lock
    int           m_last  = 0;   // cycle of the owner's most recent activity
    int           m_prev  = -1;  // requester granted in the previous cycle
    int           cyc     = 0;
    logic [N-1:0] m_gnt_last = '0;

    initial begin : cmp
        int           w;
        int           j;
        logic [N-1:0] elig;
        logic [N-1:0] eg;
        logic [N-1:0] erv;
        logic [63:0]  erd;
        bit           rel;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
                chk("rst_acc_req", 32'(bus.acc_req_o), 32'h0);
                chk("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
                chk("rst_rdata_lo", bus.rdata_o[31:0], 32'h0);
                chk("rst_rdata_hi", bus.rdata_o[63:32], 32'h0);
                chk("rst_lock_release", 32'(bus.lock_release_o), 32'h0);
                m_ptr = 0; m_owner = -1; m_prev = -1; m_gnt_last = '0;
            end else begin
                elig = (m_owner >= 0) ? (bus.req_i & (N'(1) << m_owner)) : bus.req_i;
                w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (w < 0 && elig[j]) w = j;
                end
                eg  = (w >= 0) ? (N'(1) << w) : '0;
                rel = (m_owner >= 0) && !bus.req_i[m_owner] && (cyc - m_last == LT);
                erv = '0;
                erd = '0;
                if (bus.acc_rvalid_i && m_prev >= 0) begin
                    erv[m_prev]          = 1'b1;
                    erd[32*m_prev +: 32] = bus.acc_rdata_i;
                end
                chk("gnt", 32'(bus.gnt_o), 32'(eg));
                chk("acc_req", 32'(bus.acc_req_o), 32'(w >= 0));
                chk("acc_we", 32'(bus.acc_we_o), (w >= 0) ? 32'(bus.we_i[w]) : 32'h0);
                chk("acc_be", 32'(bus.acc_be_o), (w >= 0) ? 32'(bus.be_i[4*w +: 4]) : 32'h0);
                chk("acc_addr", bus.acc_addr_o, (w >= 0) ? bus.addr_i[32*w +: 32] : 32'h0);
                chk("acc_wdata", bus.acc_wdata_o, (w >= 0) ? bus.wdata_i[32*w +: 32] : 32'h0);
                chk("rvalid", 32'(bus.rvalid_o), 32'(erv));
                chk("rdata_lo", bus.rdata_o[31:0], erd[31:0]);
                chk("rdata_hi", bus.rdata_o[63:32], erd[63:32]);
                chk("lock_release", 32'(bus.lock_release_o), 32'(rel));
                if (w >= 0) begin
                    m_ptr = (w + 1) % N;
                    if (m_owner < 0 && bus.lock_i[w]) begin
                        m_owner = w;
                        m_last  = cyc;
                    end else if (m_owner == w && !bus.lock_i[w]) begin
                        m_owner = -1;
                    end
                end
                if (m_owner >= 0 && bus.req_i[m_owner]) m_last = cyc;
                if (rel) m_owner = -1;
                m_prev     = w;
                m_gnt_last = eg;
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int i, input bit r, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit lk);
        bus.req_i[i]          = r;
        bus.we_i[i]           = we;
        bus.be_i[4*i +: 4]    = 4'hF;
        bus.addr_i[32*i +: 32]  = a;
        bus.wdata_i[32*i +: 32] = d;
        bus.lock_i[i]         = lk;
    endtask

    initial begin : stim
        int          p;
        logic [31:0] a;
        bus.req_i = '0; bus.we_i = '0; bus.be_i = '0;
        bus.addr_i = '0; bus.wdata_i = '0; bus.lock_i = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single write from requester 1
        drv(1, 1, 1, 32'h0, 32'hA5, 0);
        @(negedge clk);
        chk("t1_gnt", 32'(bus.gnt_o), 32'h2);
        chk("t1_addr", bus.acc_addr_o, 32'h0);
        chk("t1_wdata", bus.acc_wdata_o, 32'hA5);
        tick();
        drv(1, 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("t1_rvalid", 32'(bus.rvalid_o), 32'h2);

        // Both requesting, no lock: strict alternation, responses follow grants
        tick();
        drv(0, 1, 0, 32'h10, 32'h0, 0);
        drv(1, 1, 0, 32'h10, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_gnt", 32'(bus.gnt_o), (k % 2) ? 32'h2 : 32'h1);
            if (k > 0) chk("t2_rvalid", 32'(bus.rvalid_o), (k % 2) ? 32'h1 : 32'h2);
            tick();
        end
        drv(0, 0, 0, 32'h0, 32'h0, 0);
        drv(1, 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("t2_rvalid_last", 32'(bus.rvalid_o), 32'h2);

        // Locked A/B/C sequence by requester 1 while requester 0 waits
        tick();
        drv(1, 1, 1, 32'h0, 32'h0F, 1);
        @(negedge clk);
        chk("t3_gnt_a", 32'(bus.gnt_o), 32'h2);
        tick();
        drv(0, 1, 0, 32'h10, 32'h0, 0);
        drv(1, 1, 1, 32'h4, 32'hF0, 1);
        @(negedge clk);
        chk("t3_gnt_b", 32'(bus.gnt_o), 32'h2);
        tick();
        drv(1, 1, 0, 32'h10, 32'h0, 0);
        @(negedge clk);
        chk("t3_gnt_c", 32'(bus.gnt_o), 32'h2);
        tick();
        drv(1, 0, 0, 32'h0, 32'h0, 0);
        @(negedge clk);
        chk("t3_rdata", bus.rdata_o[63:32], 32'hFF);
        chk("t3_rvalid", 32'(bus.rvalid_o), 32'h2);
        chk("t3_gnt_req0", 32'(bus.gnt_o), 32'h1);
        tick();
        drv(0, 0, 0, 32'h0, 32'h0, 0);

        // Lock by requester 0, then abandoned: watchdog releases it
        tick();
        drv(0, 1, 1, 32'h0, 32'h1, 1);
        @(negedge clk);
        chk("t4_gnt_lock", 32'(bus.gnt_o), 32'h1);
        tick();
        drv(0, 0, 0, 32'h0, 32'h0, 0);
        drv(1, 1, 0, 32'h10, 32'h0, 0);
        for (int k = 1; k <= LT; k++) begin
            @(negedge clk);
            chk("t4_gnt_wait", 32'(bus.gnt_o), 32'h0);
            chk("t4_release", 32'(bus.lock_release_o), (k == LT) ? 32'h1 : 32'h0);
            tick();
        end
        @(negedge clk);
        chk("t4_gnt_after", 32'(bus.gnt_o), 32'h2);
        chk("t4_release_after", 32'(bus.lock_release_o), 32'h0);
        tick();
        drv(1, 0, 0, 32'h0, 32'h0, 0);

        // Reset while locked with a response pending
        tick();
        drv(0, 1, 1, 32'h10, 32'h0, 1);
        @(negedge clk);
        chk("t5_gnt_lock", 32'(bus.gnt_o), 32'h1);
        tick();
        drv(0, 1, 0, 32'h10, 32'h0, 0);
        drv(1, 1, 0, 32'h10, 32'h0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_gnt_in_rst", 32'(bus.gnt_o), 32'h0);
        chk("t5_acc_req_in_rst", 32'(bus.acc_req_o), 32'h0);
        chk("t5_rvalid_in_rst", 32'(bus.rvalid_o), 32'h0);
        chk("t5_rdata_in_rst", bus.rdata_o[31:0], 32'h0);
        chk("t5_release_in_rst", 32'(bus.lock_release_o), 32'h0);
        spur = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("t5_spur_rvalid", 32'(bus.rvalid_o), 32'h0);
        chk("t5_gnt_ptr0", 32'(bus.gnt_o), 32'h1);
        tick();
        @(negedge clk);
        chk("t5_gnt_next", 32'(bus.gnt_o), 32'h2);
        chk("t5_rvalid_next", 32'(bus.rvalid_o), 32'h1);
        tick();
        drv(0, 0, 0, 32'h0, 32'h0, 0);
        drv(1, 0, 0, 32'h0, 32'h0, 0);

        // Randomized traffic; the compare process checks every cycle
        p = 5;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c % 200 == 0) p = $urandom_range(1, 9);
            rst_n = ($urandom_range(0, 599) != 0);
            spur  = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_i[i] || m_gnt_last[i]) begin
                    case ($urandom_range(0, 2))
                        0:       a = 32'h0;
                        1:       a = 32'h4;
                        default: a = 32'h10;
                    endcase
                    drv(i, $urandom_range(0, 9) < p, 1'($urandom_range(0, 1)), a,
                        $urandom, $urandom_range(0, 2) == 0);
                    bus.be_i[4*i +: 4] = 4'($urandom);
                end
            end
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
